// File: rtl/prbs_gen_multi.sv
// PRBS pattern generator: NSEG parallel 24-bit Fibonacci LFSRs (x^24+x^23+x^22+x^17+1)
// fill an OUT_W-bit word. Each run opens with a start-pattern burst, then emits PRBS
// words while EN is high, with optional single-shot or continuous error injection.
module prbs_gen_multi #(
  parameter int               OUT_W     = 112,
  parameter logic [191:0]     SEED_VEC  = {24'h1, 24'h1, 24'h1, 24'hACA519,
                                           24'h67AFB1, 24'h5A10AF, 24'hE26B38, 24'h83B62E},
  parameter logic [OUT_W-1:0] START_PAT = 112'h5555555555555500000000000000,
  parameter int               START_LEN = 1,
  parameter logic [OUT_W-1:0] ERR_MASK  = 112'h0101010101010101010101010101
) (
  input  logic             GEN_CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             INJ_ERR,
  input  logic             INJ_MODE,
  output logic [OUT_W-1:0] PRBS,
  output logic             STRT_LTNCY,
  output logic             RUNNING,
  output logic [31:0]      WORD_CNT,
  output logic [15:0]      INJ_CNT
);

  localparam int         NSEG = (OUT_W + 23) / 24;
  localparam logic [7:0] SLEN = 8'(START_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] prbs_q, prbs_d;
  logic [OUT_W-1:0] payload;
  logic             strt_q, strt_d;
  logic             running_q, running_d;
  logic [7:0]       scnt_q, scnt_d;
  logic [23:0]      seg_q [NSEG];
  logic [23:0]      seg_d [NSEG];
  logic [31:0]      wcnt_q, wcnt_d;
  logic [15:0]      icnt_q, icnt_d;
  logic             pend_q, pend_d;
  logic             prev_q;
  logic             inj;

  // Seed for segment i; an all-zero seed would lock the LFSR, so it becomes 1.
  function automatic logic [23:0] seed_of(input int i);
    logic [23:0] s;
    s = SEED_VEC[24*i +: 24];
    return (s == 24'h0) ? 24'h000001 : s;
  endfunction

  // One Fibonacci step, taps 24/23/22/17.
  function automatic logic [23:0] lfsr_step(input logic [23:0] s);
    return {s[22:0], s[23] ^ s[22] ^ s[21] ^ s[16]};
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Concatenate segments with seg0 most significant; the top bits of seg0 fall off.
  for (genvar i = 0; i < NSEG; i++) begin : g_cat
    localparam int LO = (NSEG - 1 - i) * 24;
    localparam int HI = (LO + 23 > OUT_W - 1) ? OUT_W - 1 : LO + 23;
    assign payload[HI:LO] = seg_q[i][HI-LO:0];
  end

  // Continuous mode injects on the live input; single-shot uses the latched request.
  assign inj = INJ_MODE ? INJ_ERR : pend_q;

  // Next-state, output word, LFSR advance and counters.
  always_comb begin
    state_d = state_q;
    prbs_d  = prbs_q;
    strt_d  = 1'b0;
    scnt_d  = scnt_q;
    seg_d   = seg_q;
    wcnt_d  = wcnt_q;
    icnt_d  = icnt_q;
    case (state_q)
      IDLE: begin
        prbs_d  = START_PAT;
        strt_d  = 1'b1;
        scnt_d  = 8'd1;
        state_d = (SLEN == 8'd1) ? RUN : START;
      end
      START: begin
        prbs_d = START_PAT;
        scnt_d = scnt_q + 8'd1;
        if (scnt_d == SLEN) state_d = RUN;
      end
      RUN: begin
        if (EN) begin
          prbs_d = payload ^ (inj ? ERR_MASK : '0);
          for (int i = 0; i < NSEG; i++) seg_d[i] = lfsr_step(seg_q[i]);
          wcnt_d = wcnt_q + 32'd1;
          if (inj) icnt_d = sat_inc16(icnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
  end

  // Single-shot request latch: set on a rising edge, consumed by the next emitted RUN word.
  always_comb begin
    pend_d = pend_q;
    if ((state_q == RUN) && !EN) pend_d = pend_q;
    else if (INJ_MODE)           pend_d = 1'b0;
    else if (pend_q)             pend_d = (state_q != RUN);
    else                         pend_d = INJ_ERR & ~prev_q;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge GEN_CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      prbs_q    <= '0;
      strt_q    <= 1'b0;
      running_q <= 1'b0;
      scnt_q    <= 8'd0;
      wcnt_q    <= 32'd0;
      icnt_q    <= 16'd0;
      pend_q    <= 1'b0;
      prev_q    <= 1'b0;
      for (int i = 0; i < NSEG; i++) seg_q[i] <= seed_of(i);
    end else begin
      state_q   <= state_d;
      prbs_q    <= prbs_d;
      strt_q    <= strt_d;
      running_q <= running_d;
      scnt_q    <= scnt_d;
      wcnt_q    <= wcnt_d;
      icnt_q    <= icnt_d;
      pend_q    <= pend_d;
      prev_q    <= INJ_ERR;
      for (int i = 0; i < NSEG; i++) seg_q[i] <= seg_d[i];
    end
  end

  assign PRBS       = prbs_q;
  assign STRT_LTNCY = strt_q;
  assign RUNNING    = running_q;
  assign WORD_CNT   = wcnt_q;
  assign INJ_CNT    = icnt_q;

endmodule

// File: tb/tb_prbs_gen_multi.sv
// Bench for prbs_gen_multi: two instances (START_LEN 1 and 3) share stimulus; a
// sequence-index reference model feeds per-instance expectation queues that a
// separate monitor drains every cycle.
module tb_prbs_gen_multi;

  localparam logic [111:0] START_PAT = 112'h5555555555555500000000000000;
  localparam logic [111:0] MASK      = 112'h0101010101010101010101010101;
  localparam logic [111:0] SEED_WORD = 112'hB62E_E26B38_5A10AF_67AFB1_ACA519;

  typedef struct {
    logic [111:0] prbs;
    logic         strt;
    logic         run;
    logic [31:0]  wc;
    logic [15:0]  ic;
  } exp_t;

  logic clk = 1'b0;
  logic rst, en, inj_err, inj_mode;
  logic [111:0] p0, p3;
  logic         s0, s3, r0, r3;
  logic [31:0]  w0, w3;
  logic [15:0]  i0, i3;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  // reference model state
  logic [23:0]  g[5];
  logic [111:0] seq[$];
  int           slen[2];
  int           sidx[2];
  int unsigned  widx[2];
  bit           pend[2], prev[2];
  logic [111:0] mout[2];
  bit           mstrt[2], mrun[2];
  logic [31:0]  mwc[2];
  logic [15:0]  mic[2];

  always #5 clk = ~clk;

  prbs_gen_multi u0 (
    .GEN_CLK(clk), .RST(rst), .EN(en), .INJ_ERR(inj_err), .INJ_MODE(inj_mode),
    .PRBS(p0), .STRT_LTNCY(s0), .RUNNING(r0), .WORD_CNT(w0), .INJ_CNT(i0)
  );

  prbs_gen_multi #(.START_LEN(3)) u3 (
    .GEN_CLK(clk), .RST(rst), .EN(en), .INJ_ERR(inj_err), .INJ_MODE(inj_mode),
    .PRBS(p3), .STRT_LTNCY(s3), .RUNNING(r3), .WORD_CNT(w3), .INJ_CNT(i3)
  );

  task automatic chk(input string nm, input logic [111:0] act, input logic [111:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // k-th PRBS payload word after reset, generated on demand from the polynomial
  function automatic logic [111:0] seq_at(input int unsigned k);
    while (seq.size() <= int'(k)) begin
      seq.push_back({g[0][15:0], g[1], g[2], g[3], g[4]});
      for (int j = 0; j < 5; j++) g[j] = {g[j][22:0], ^(g[j] & 24'hE10000)};
    end
    return seq[k];
  endfunction

  function automatic void model_step(input bit r, input bit e, input bit ie, input bit md);
    for (int d = 0; d < 2; d++) begin
      bit   rise;
      bit   inj;
      exp_t x;
      if (r) begin
        sidx[d] = 0; widx[d] = 0; pend[d] = 0; prev[d] = 0;
        mout[d] = '0; mstrt[d] = 0; mrun[d] = 0; mwc[d] = 0; mic[d] = 0;
      end else begin
        rise     = ie && !prev[d];
        mstrt[d] = 0;
        if (sidx[d] < slen[d]) begin
          mout[d]  = START_PAT;
          mstrt[d] = (sidx[d] == 0);
          sidx[d]++;
          if (md) pend[d] = 0;
          else if (rise) pend[d] = 1;
        end else if (e) begin
          inj     = md ? ie : pend[d];
          mout[d] = seq_at(widx[d]) ^ (inj ? MASK : 112'h0);
          widx[d]++;
          mwc[d]++;
          if (inj && mic[d] != 16'hFFFF) mic[d]++;
          if (md || pend[d]) pend[d] = 0;
          else pend[d] = rise;
        end
        mrun[d] = (sidx[d] == slen[d]);
        prev[d] = ie;
      end
      x.prbs = mout[d]; x.strt = mstrt[d]; x.run = mrun[d]; x.wc = mwc[d]; x.ic = mic[d];
      if (d == 0) q0.push_back(x);
      else        q1.push_back(x);
    end
  endfunction

  task automatic cyc(input bit r, input bit e, input bit ie, input bit md);
    @(negedge clk);
    rst = r; en = e; inj_err = ie; inj_mode = md;
    model_step(r, e, ie, md);
  endtask

  // monitor: one expected entry per instance per clock edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (q0.size() > 0) begin
        x = q0.pop_front();
        chk("u0_prbs", p0, x.prbs);
        chk("u0_strt", 112'(s0), 112'(x.strt));
        chk("u0_running", 112'(r0), 112'(x.run));
        chk("u0_word_cnt", 112'(w0), 112'(x.wc));
        chk("u0_inj_cnt", 112'(i0), 112'(x.ic));
      end
      if (q1.size() > 0) begin
        x = q1.pop_front();
        chk("u3_prbs", p3, x.prbs);
        chk("u3_strt", 112'(s3), 112'(x.strt));
        chk("u3_running", 112'(r3), 112'(x.run));
        chk("u3_word_cnt", 112'(w3), 112'(x.wc));
        chk("u3_inj_cnt", 112'(i3), 112'(x.ic));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit m;
    bit ie;
    m = 0; ie = 0;
    rst = 1; en = 0; inj_err = 0; inj_mode = 0;
    g[0] = 24'h83B62E; g[1] = 24'hE26B38; g[2] = 24'h5A10AF; g[3] = 24'h67AFB1; g[4] = 24'hACA519;
    slen[0] = 1; slen[1] = 3;

    repeat (3) cyc(1, 0, 0, 0);

    cyc(0, 1, 0, 0); @(posedge clk); #3;
    chk("t1_start_pat", p0, START_PAT);
    chk("t1_strt_pulse", 112'(s0), 112'(1));
    cyc(0, 1, 0, 0); @(posedge clk); #3;
    chk("t1_seed_word", p0, SEED_WORD);
    chk("t1_running", 112'(r0), 112'(1));
    chk("t1_word_cnt", 112'(w0), 112'(1));
    cyc(0, 1, 0, 0); @(posedge clk); #3;
    chk("t2_low_seg", 112'(p0[23:0]), 112'(24'h594A32));
    chk("t2_word_cnt", 112'(w0), 112'(2));
    cyc(0, 1, 0, 0); @(posedge clk); #3;
    chk("t6_len3_seed_word", p3, SEED_WORD);
    chk("t1_word_cnt3", 112'(w0), 112'(3));

    repeat (5) cyc(0, 0, 0, 0);
    @(posedge clk); #3;
    chk("t3_frozen_cnt", 112'(w0), 112'(3));
    cyc(0, 1, 0, 0); @(posedge clk); #3;
    chk("t3_resume_cnt", 112'(w0), 112'(4));

    repeat (4) cyc(0, 1, 1, 0);
    repeat (2) cyc(0, 1, 0, 0);
    @(posedge clk); #3;
    chk("t4_single_shot", 112'(i0), 112'(1));
    cyc(0, 1, 1, 0);
    repeat (2) cyc(0, 1, 0, 0);
    @(posedge clk); #3;
    chk("t4_second_pulse", 112'(i0), 112'(2));

    cyc(1, 1, 0, 0); @(posedge clk); #3;
    chk("t6_rst_prbs", p0, 112'h0);
    chk("t6_rst_running", 112'(r0), 112'(0));
    chk("t6_rst_word_cnt", 112'(w0), 112'(0));
    chk("t6_rst_inj_cnt", 112'(i0), 112'(0));
    chk("t6_rst_prbs3", p3, 112'h0);
    cyc(0, 1, 0, 0); @(posedge clk); #3;
    chk("t6_sp1", p3, START_PAT);
    chk("t6_sp1_strt", 112'(s3), 112'(1));
    cyc(0, 1, 0, 0); @(posedge clk); #3;
    chk("t6_sp2", p3, START_PAT);
    chk("t6_sp2_strt", 112'(s3), 112'(0));
    chk("t6_sp2_running", 112'(r3), 112'(0));
    cyc(0, 1, 0, 0); @(posedge clk); #3;
    chk("t6_sp3", p3, START_PAT);
    chk("t6_sp3_running", 112'(r3), 112'(1));
    cyc(0, 1, 0, 0); @(posedge clk); #3;
    chk("t6_seed_after_burst", p3, SEED_WORD);
    chk("t6_word_cnt3", 112'(w3), 112'(1));

    repeat (3) cyc(0, 1, 1, 1);
    cyc(0, 1, 0, 1); @(posedge clk); #3;
    chk("t5_continuous", 112'(i0), 112'(3));
    chk("t5_continuous3", 112'(i3), 112'(3));

    for (int i = 0; i < 10500; i++) begin
      if (($urandom % 10) == 0) ie = !ie;
      if (($urandom % 200) == 0) m = !m;
      cyc(i == 5000, ($urandom % 8) != 0, ie, m);
    end
    cyc(0, 1, 0, 0);
    repeat (2) @(posedge clk);
    #4;
    chk("queue0_drained", 112'(q0.size()), 112'(0));
    chk("queue1_drained", 112'(q1.size()), 112'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
